// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID pipeline register, 32x32 register file with
// optional write-to-read forwarding, field/immediate decode and branch/jump resolution.
module id_stage #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] pc_out,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm_sext,
  output logic [31:0] id_imm_zext,
  output logic        id_br,
  output logic [31:0] id_br_target,
  output logic        id_jump,
  output logic [31:0] id_jtarget
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [XLEN-1:0] r_rf [NREGS];

  logic [XLEN-1:0] w_pc4;
  logic            w_rs_byp;
  logic            w_rt_byp;
  logic            w_eq;

  // IF/ID register: flush outranks stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_instr <= if_instr;
      r_pc    <= pc_out;
      r_valid <= if_valid;
    end
  end

  // Write-back is independent of stall/flush; r0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_we && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  assign id_valid    = r_valid;
  assign id_pc       = r_pc;
  assign id_opcode   = r_instr[31:26];
  assign id_rs       = r_instr[25:21];
  assign id_rt       = r_instr[20:16];
  assign id_rd       = r_instr[15:11];
  assign id_shamt    = r_instr[10:6];
  assign id_funct    = r_instr[5:0];
  assign id_imm_sext = {{16{r_instr[15]}}, r_instr[15:0]};
  assign id_imm_zext = {16'h0000, r_instr[15:0]};

  assign w_rs_byp = BYPASS && wb_we && (wb_addr == id_rs);
  assign w_rt_byp = BYPASS && wb_we && (wb_addr == id_rt);

  assign id_rs_data = (id_rs == 5'd0) ? '0 : (w_rs_byp ? wb_data : r_rf[id_rs]);
  assign id_rt_data = (id_rt == 5'd0) ? '0 : (w_rt_byp ? wb_data : r_rf[id_rt]);

  assign w_pc4 = r_pc + 32'd4;
  assign w_eq  = (id_rs_data == id_rt_data);

  assign id_br_target = w_pc4 + {id_imm_sext[29:0], 2'b00};
  assign id_jtarget   = {w_pc4[31:28], r_instr[25:0], 2'b00};

  assign id_br   = r_valid && (((id_opcode == OP_BEQ) && w_eq) ||
                               ((id_opcode == OP_BNE) && !w_eq));
  assign id_jump = r_valid && ((id_opcode == OP_J) || (id_opcode == OP_JAL));

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instr, pc_out;
  logic        if_valid, stall, flush, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid, id_br, id_jump;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm_sext, id_imm_zext;
  logic [31:0] id_br_target, id_jtarget;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_instr, m_pc;
  logic        m_valid;

  id_stage #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .pc_out(pc_out), .if_valid(if_valid),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_sext(id_imm_sext),
    .id_imm_zext(id_imm_zext), .id_br(id_br), .id_br_target(id_br_target),
    .id_jump(id_jump), .id_jtarget(id_jtarget)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int unsigned a);
    if (a == 0) return 32'd0;
    if (wb_we && (int'(wb_addr) == a)) return wb_data;
    return m_regs[a];
  endfunction

  // Apply one rising edge to the model using the inputs present at that edge
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instr = 0; m_pc = 0; m_valid = 0;
    end else begin
      if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
      if (flush) begin
        m_instr = 0; m_pc = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = if_instr; m_pc = pc_out; m_valid = if_valid;
      end
    end
  endtask

  task automatic check_all();
    int unsigned op, rs, rt;
    logic [31:0] a, b, imm, sext, pc4, exp_br_tgt, exp_jt;
    logic exp_br, exp_j;
    op   = m_instr / (2**26);
    rs   = (m_instr / (2**21)) % 32;
    rt   = (m_instr / (2**16)) % 32;
    imm  = m_instr % 65536;
    sext = (imm >= 32768) ? imm - 32'd65536 : imm;
    a    = m_read(rs);
    b    = m_read(rt);
    pc4  = m_pc + 32'd4;
    exp_br_tgt = pc4 + sext * 32'd4;
    exp_jt     = (pc4 & 32'hF000_0000) | ((m_instr % (2**26)) * 32'd4);
    exp_br = m_valid && ((op == 4 && a == b) || (op == 5 && a != b));
    exp_j  = m_valid && (op == 2 || op == 3);
    chk("valid",   32'(id_valid), 32'(m_valid));
    chk("pc",      id_pc, m_pc);
    chk("opcode",  32'(id_opcode), op);
    chk("rs",      32'(id_rs), rs);
    chk("rt",      32'(id_rt), rt);
    chk("rd",      32'(id_rd), (m_instr / (2**11)) % 32);
    chk("shamt",   32'(id_shamt), (m_instr / (2**6)) % 32);
    chk("funct",   32'(id_funct), m_instr % 64);
    chk("rs_data", id_rs_data, a);
    chk("rt_data", id_rt_data, b);
    chk("sext",    id_imm_sext, sext);
    chk("zext",    id_imm_zext, imm);
    chk("br",      32'(id_br), 32'(exp_br));
    chk("br_tgt",  id_br_target, exp_br_tgt);
    chk("jump",    32'(id_jump), 32'(exp_j));
    chk("jtarget", id_jtarget, exp_jt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    if_instr = instr; pc_out = pc; if_valid = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
    m_instr = 'x; m_pc = 'x; m_valid = 1'bx;
    rst = 1; if_instr = 32'hFFFF_FFFF; pc_out = 32'h1234; if_valid = 1;
    stall = 1; flush = 0; wb_we = 1; wb_addr = 5'd7; wb_data = 32'h5555;
    step();
    chk("rst_br_tgt", id_br_target, 32'd4);
    chk("rst_jt", id_jtarget, 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    rst = 0; stall = 0; wb_we = 0;

    // lw r2, 4(r1)
    load(32'h8C22_0004, 32'h100);
    chk("lw_pc", id_pc, 32'h100);
    chk("lw_rs", 32'(id_rs), 32'd1);
    chk("lw_rt", 32'(id_rt), 32'd2);
    chk("lw_sext", id_imm_sext, 32'd4);

    // beq r3,r3 after writing r3
    wb_we = 1; wb_addr = 5'd3; wb_data = 32'h1234_5678;
    if_instr = 0; if_valid = 0;
    step();
    wb_we = 0;
    load(32'h1063_0002, 32'h200);
    chk("beq_br", 32'(id_br), 32'd1);
    chk("beq_tgt", id_br_target, 32'h20C);
    chk("beq_rs_data", id_rs_data, 32'h1234_5678);

    // beq r0,r0,-1 at pc 0: target wraps back to 0
    load(32'h1000_FFFF, 32'h0);
    chk("neg_br", 32'(id_br), 32'd1);
    chk("neg_tgt", id_br_target, 32'h0);
    chk("neg_sext", id_imm_sext, 32'hFFFF_FFFF);
    chk("neg_zext", id_imm_zext, 32'h0000_FFFF);

    // Same-cycle forwarding of r5, then write to r0 ignored
    load(32'h00A0_0000, 32'h40);
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    #1;
    chk("byp_rs", id_rs_data, 32'hDEAD);
    check_all();
    wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    load(32'h0000_0000, 32'h44);
    #1;
    chk("r0_byp", id_rs_data, 32'd0);
    wb_we = 0;
    step();
    chk("r0_read", id_rs_data, 32'd0);

    // Stall holds for three cycles, then stall+flush kills
    load(32'h1000_0003, 32'h300);
    chk("pre_stall_br", 32'(id_br), 32'd1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if_instr = $urandom; pc_out = $urandom;
      step();
      chk("stall_pc", id_pc, 32'h300);
    end
    flush = 1;
    step();
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_br", 32'(id_br), 32'd0);
    stall = 0; flush = 0;

    // jal with upper PC bits preserved
    load(32'h0C00_0040, 32'hA000_0000);
    chk("jal_jump", 32'(id_jump), 32'd1);
    chk("jal_tgt", id_jtarget, 32'hA000_0100);

    // Reset mid-stall clears held word; load resumes only when stall drops
    load(32'h0800_0001, 32'h500);
    stall = 1; rst = 1;
    step();
    rst = 0;
    step();
    chk("post_rst_hold", 32'(id_valid), 32'd0);
    stall = 0;
    load(32'h1443_0010, 32'h600);
    chk("post_rst_load", id_pc, 32'h600);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'd2; 1: op = 6'd3; 2: op = 6'd4; 3: op = 6'd5; 4: op = 6'd0;
        default: op = 6'($urandom);
      endcase
      if_instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      pc_out   = $urandom;
      if_valid = 1'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      wb_we    = 1'($urandom);
      wb_addr  = 5'($urandom_range(0, 4));
      wb_data  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      rst      = ($urandom_range(0, 49) == 0);
      #1;
      check_all();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
